serial_tx_bit_clocked: RTL and testbench
========================================

Name: serial_tx_bit_clocked

Overview:
- Serial transmitter that consumes the divided bit-rate clock produced by the team's clock divider.
- Both blocks run on the same `old_clock` domain. The divided output arrives here as `bit_clock`, and its rising edges are converted internally to single-cycle bit ticks.
- Sends one parallel word per frame, LSB first: start bit (0), DATA_WIDTH data bits, STOP_BITS stop bits (1).
- Sits between the divider and the board's serial line output.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 1..16)
- STOP_BITS, 1, number of stop bits per frame (legal range 1..2)

Ports:
- old_clock  input  1  system clock; all logic on its rising edge
- reset  input  1  asynchronous active-low reset
- bit_clock  input  1  divided clock from the divider; synchronous to old_clock; each rising edge is one bit period
- tx_data  input  DATA_WIDTH  word to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  block can accept a word (high only in IDLE)
- tx_out  output  1  serial line; idles high
- busy  output  1  frame in progress (any state other than IDLE)
- frame_done  output  1  one-cycle pulse when the last stop bit period ends

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
  - Ports are named `old_clock` and `reset`.
  - `reset == 0` acts immediately, regardless of old_clock.
- Reset values:
  - tx_out=1, tx_ready=1, busy=0, frame_done=0
  - state=IDLE, bit index=0, stop count=0, shift register=0
  - edge-detect register `bit_clock_q`=1. This matches the divider's high output just after reset, so no spurious tick occurs at reset release.
- Tick generation: `bit_tick = bit_clock & ~bit_clock_q`. `bit_clock_q` is registered every cycle.
- Handshake:
  - Accept occurs in the cycle where `tx_valid && tx_ready` at a rising edge.
  - On accept, tx_data is latched into the shift register and the state moves to SYNC.
  - tx_ready drops the next cycle.
  - tx_valid and tx_data are ignored while tx_ready=0; no queueing.
- State machine (all outputs registered; transitions only on bit_tick except IDLE→SYNC):
  - IDLE: tx_out=1, tx_ready=1. Accept → SYNC.
  - SYNC: tx_out=1. On tick → START, tx_out<=0.
    - SYNC aligns the start bit to a full bit period.
    - A tick in the same cycle as the accept is not used.
  - START: on tick → DATA, tx_out<=shift[0], index<=0.
  - DATA: on tick:
    - if index==DATA_WIDTH-1 → STOP, tx_out<=1, stop count<=0
    - else shift right, tx_out<=next bit, index++
  - STOP: on tick:
    - if stop count==STOP_BITS-1 → IDLE, tx_ready<=1, frame_done<=1 for exactly one cycle
    - else stop count++
- Bit timing:
  - Every bit lasts exactly one bit_clock period, i.e. tick-to-tick.
  - A frame occupies 1+DATA_WIDTH+STOP_BITS periods after the SYNC wait.
- Back-to-back frames:
  - tx_valid held high through frame_done gives a new accept in the first IDLE cycle.
  - The next start bit then follows after one SYNC wait; the line stays 1 between frames.
- bit_clock stuck (constant 0 or 1): no ticks. The block waits indefinitely in its current state with tx_out held; there is no timeout.
- Reset mid-frame: tx_out returns to 1 immediately and the state returns to IDLE. No frame_done is issued and the partial frame is discarded.
- Widths:
  - Index counter: $clog2(DATA_WIDTH) bits, minimum 1.
  - Stop counter: 1 bit.
  - No arithmetic overflow is possible within the legal parameter ranges.

Test Plan:
- Reset and idle:
  - Assert reset=0 mid-sim with bit_clock toggling → tx_out=1, tx_ready=1, busy=0 immediately.
  - After release with no tx_valid, tx_out stays 1 indefinitely.
- Single frame:
  - Stimulus: bit_clock from a divide-by-4 divider (high 2 cycles, low 2 cycles); tx_data=8'hA5 with one-cycle tx_valid.
  - Required line sequence, each level held exactly 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - frame_done pulses once; tx_ready returns to 1.
- Handshake:
  - Hold tx_valid=1 with tx_data=8'h3C while busy → only the first word is sent.
  - Keep tx_valid high through frame_done → the next frame (8'h3C) starts after one SYNC wait.
  - No extra frame is sent.
- Reset mid-frame:
  - Pulse reset low during data bit 3 of 8'hFF → tx_out=1 asynchronously and state returns to IDLE.
  - No frame_done.
  - The next accepted word transmits correctly.
- Stalled bit_clock: hold bit_clock=1 after accept → busy=1 and tx_out=1 persist for 100 cycles. Resume toggling → the frame completes normally.
- Parameters: DATA_WIDTH=5, STOP_BITS=2, tx_data=5'b10011.
  - Required line: 0,1,1,0,0,1,1,1 (two stop bits).
  - frame_done occurs 8 bit periods after the start bit begins.

Source files
------------

// File: rtl/serial_tx_bit_clocked.sv
// serial_tx_bit_clocked: LSB-first serial transmitter paced by rising edges of a divided bit clock
module serial_tx_bit_clocked #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                  old_clock,
  input  logic                  reset,
  input  logic                  bit_clock,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [IW-1:0] idx, idx_n;
  logic stop_cnt, stop_n, tx_n, done_n, bit_clock_q, bit_tick;
  assign bit_tick = bit_clock & ~bit_clock_q;
  assign tx_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge old_clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shift <= '0;
      idx <= '0;
      stop_cnt <= 1'b0;
      tx_out <= 1'b1;
      frame_done <= 1'b0;
      bit_clock_q <= 1'b1;
    end else begin
      state <= state_n;
      shift <= shift_n;
      idx <= idx_n;
      stop_cnt <= stop_n;
      tx_out <= tx_n;
      frame_done <= done_n;
      bit_clock_q <= bit_clock;
    end
  end
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n = idx;
    stop_n = stop_cnt;
    tx_n = tx_out;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (tx_valid) begin
          state_n = SYNC;
          shift_n = tx_data;
        end
      end
      SYNC: if (bit_tick) begin
        state_n = START;
        tx_n = 1'b0;
      end
      START: if (bit_tick) begin
        state_n = DATA;
        tx_n = shift[0];
        idx_n = '0;
      end
      DATA: if (bit_tick) begin
        if (idx == IW'(DATA_WIDTH - 1)) begin
          state_n = STOP;
          tx_n = 1'b1;
          stop_n = 1'b0;
        end else begin
          shift_n = shift >> 1;
          tx_n = shift_n[0];
          idx_n = idx + 1'b1;
        end
      end
      STOP: if (bit_tick) begin
        if (stop_cnt == 1'(STOP_BITS - 1)) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else begin
          stop_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_tx_bit_clocked.sv
// tb_serial_tx_bit_clocked: directed checks of framing, handshake, reset and stall behaviour
module tb_serial_tx_bit_clocked;
  logic old_clock, reset, bit_clock, stall;
  logic [1:0] div;
  logic [7:0] tx_data_a;
  logic [4:0] tx_data_b;
  logic tx_valid_a, tx_valid_b;
  logic tx_ready_a, tx_out_a, busy_a, frame_done_a;
  logic tx_ready_b, tx_out_b, busy_b, frame_done_b;
  int checks, failures, fd_a, fd_b, last_gap;

  serial_tx_bit_clocked dut_a (
    .old_clock(old_clock), .reset(reset), .bit_clock(bit_clock),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .tx_out(tx_out_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  serial_tx_bit_clocked #(.DATA_WIDTH(5), .STOP_BITS(2)) dut_b (
    .old_clock(old_clock), .reset(reset), .bit_clock(bit_clock),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .tx_out(tx_out_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  initial begin
    old_clock = 0;
    forever #5 old_clock = ~old_clock;
  end

  // Divide-by-4 bit clock: high two cycles, low two; stall forces it high
  initial begin
    div = 0;
    bit_clock = 1;
    stall = 0;
    forever begin
      @(negedge old_clock);
      div = div + 1;
      bit_clock = stall | ~div[1];
    end
  end

  always @(negedge old_clock) begin
    if (frame_done_a === 1'b1) fd_a++;
    if (frame_done_b === 1'b1) fd_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return sel != 0 ? tx_out_b : tx_out_a;
  endfunction

  task automatic find_start(input int sel, output int n);
    n = 0;
    while (line(sel) !== 1'b0 && n < 400) begin
      @(negedge old_clock);
      n++;
    end
  endtask

  task automatic frame(input string tag, input int sel, input logic [15:0] bits, input int nbits);
    int n;
    logic [3:0] s;
    find_start(sel, n);
    last_gap = n;
    chk({tag, "_start_seen"}, n < 400, 1);
    if (n >= 400) return;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < 4; j++) begin
        s[j] = line(sel);
        @(negedge old_clock);
      end
      chk($sformatf("%s_bit%0d", tag, i), s, {4{bits[i]}});
    end
    chk({tag, "_done"}, sel != 0 ? frame_done_b : frame_done_a, 1);
    chk({tag, "_ready"}, sel != 0 ? tx_ready_b : tx_ready_a, 1);
    @(negedge old_clock);
    chk({tag, "_done_clear"}, sel != 0 ? frame_done_b : frame_done_a, 0);
  endtask

  task automatic quiet(input string tag, input int cyc, input logic exp_busy);
    int bad;
    bad = 0;
    repeat (cyc) begin
      if (tx_out_a !== 1'b1 || busy_a !== exp_busy) bad++;
      @(negedge old_clock);
    end
    chk(tag, bad, 0);
  endtask

  task automatic send_a(input logic [7:0] d);
    tx_data_a = d;
    tx_valid_a = 1;
    @(negedge old_clock);
    tx_valid_a = 0;
  endtask

  initial begin
    int n, fd0;
    checks = 0; failures = 0; fd_a = 0; fd_b = 0;
    reset = 0;
    tx_valid_a = 0; tx_valid_b = 0; tx_data_a = 0; tx_data_b = 0;
    repeat (3) @(negedge old_clock);
    chk("rst_tx_out", tx_out_a, 1);
    chk("rst_ready", tx_ready_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", frame_done_a, 0);
    chk("rst_b_line", {tx_out_b, tx_ready_b, busy_b}, 3'b110);
    reset = 1;
    quiet("idle_line", 60, 0);

    send_a(8'hA5);
    chk("accept_ready_low", tx_ready_a, 0);
    chk("accept_busy", busy_a, 1);
    frame("a5", 0, {1'b1, 8'hA5, 1'b0}, 10);
    chk("a5_one_done", fd_a, 1);

    // Valid stays high across the whole frame; the data change must not leak in
    tx_data_a = 8'hC3;
    tx_valid_a = 1;
    @(negedge old_clock);
    tx_data_a = 8'h3C;
    frame("c3", 0, {1'b1, 8'hC3, 1'b0}, 10);
    tx_valid_a = 0;
    frame("3c", 0, {1'b1, 8'h3C, 1'b0}, 10);
    chk("b2b_gap", last_gap, 3);
    quiet("no_extra_frame", 80, 0);
    chk("b2b_done_count", fd_a, 3);

    send_a(8'hFF);
    find_start(0, n);
    chk("ff_start_seen", n < 400, 1);
    repeat (17) @(negedge old_clock);
    chk("ff_mid_busy", busy_a, 1);
    fd0 = fd_a;
    #2 reset = 0;
    #1;
    chk("mid_rst_tx_out", tx_out_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_ready", tx_ready_a, 1);
    repeat (3) @(negedge old_clock);
    reset = 1;
    quiet("post_rst_idle", 60, 0);
    chk("mid_rst_no_done", fd_a, fd0);
    send_a(8'h96);
    frame("96", 0, {1'b1, 8'h96, 1'b0}, 10);

    stall = 1;
    repeat (4) @(negedge old_clock);
    send_a(8'h4B);
    quiet("stall_hold", 100, 1);
    stall = 0;
    frame("4b", 0, {1'b1, 8'h4B, 1'b0}, 10);

    tx_data_b = 5'b10011;
    tx_valid_b = 1;
    @(negedge old_clock);
    tx_valid_b = 0;
    frame("p5", 1, {2'b11, 5'b10011, 1'b0}, 8);
    chk("p5_done_count", fd_b, 1);
    chk("a_total_done", fd_a, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
